uart_tx: RTL

//  Serial RS-232 transmitter of the microcontroller: takes a byte from the DMA/CPU

---
 rtl/global_pkg.sv | 16 +
 rtl/uart_baud_gen.sv | 39 +++
 rtl/uart_tx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/global_pkg.sv
// Shared types and defaults for the serial link blocks.
// Holds the transmitter state encoding and clock/baud defaults.
package global_pkg;

    localparam int CLK_FREQ_HZ = 20_000_000;
    localparam int UART_BAUD   = 115_200;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period cycle counter for the UART transmitter.
// Tick marks the last clock of each bit; Clear holds the count at zero.
module uart_baud_gen
    import global_pkg::*;
#(
    parameter int BIT_CYCLES = 2
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Clear,
    output logic Tick
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign Tick = (cnt_q == TERM);

    // Count 0..BIT_CYCLES-1, wrapping at terminal count or on Clear
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (Clear || Tick) begin
            cnt_d = '0;
        end
    end

    // Cycle counter register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ack byte intake, start/data/parity/stop framing.
// TXD is registered so the line is glitch-free and idles high.
module uart_tx
    import global_pkg::*;
#(
    parameter int CLK_FREQ  = CLK_FREQ_HZ,
    parameter int BAUD_RATE = UART_BAUD,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] Data,
    input  logic       Valid_D,
    output logic       Ack_in,
    output logic       TX_RDY,
    output logic       TXD
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;

    if (BIT_CYCLES < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q,   bit_d;
    logic       par_q,   par_d;
    logic       txd_q,   txd_d;
    logic       ack_q,   ack_d;
    logic       tick;
    logic       clear;

    // Counter idles at zero so the first bit starts on the accept edge
    assign clear = (state_q == TX_IDLE);

    uart_baud_gen #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_baud (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .Clear(clear),
        .Tick (tick)
    );

    assign Ack_in = ack_q;
    assign TX_RDY = (state_q == TX_IDLE);
    assign TXD    = txd_q;

    // Next-state, shift and line level for the following clock
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        txd_d   = txd_q;
        ack_d   = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (Valid_D) begin
                    shift_d = Data;
                    par_d   = ^Data;
                    bit_d   = 3'd0;
                    ack_d   = 1'b1;
                    txd_d   = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    txd_d   = shift_q[0];
                    bit_d   = 3'd0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        if (PARITY_EN != 0) begin
                            txd_d   = par_q;
                            state_d = TX_PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = TX_STOP;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    bit_d   = 3'd0;
                    txd_d   = 1'b1;
                    state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        bit_d   = 3'd0;
                        state_d = TX_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = TX_IDLE;
            end
        endcase
    end

    // State, shift register and output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= TX_IDLE;
            shift_q <= 8'h00;
            bit_q   <= 3'd0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ack_q   <= ack_d;
        end
    end

endmodule
